// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the execute stage and alu_pipe.
// The master side drives the operation and consumes the result; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             flag_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             z;
  logic             v;
  logic             c;
  logic [3:0]       flags_q;

  modport master (
    output in_valid, a, b, sel, flag_we, out_ready,
    input  in_ready, out_valid, result, n, z, v, c, flags_q
  );

  modport slave (
    input  in_valid, a, b, sel, flag_we, out_ready,
    output in_ready, out_valid, result, n, z, v, c, flags_q
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, barrel shifter, iterative shift-add multiplier
// and a sticky {N,Z,V,C} register updated when a flag-writing result is consumed.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpAsr = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;

  localparam logic [SHW-1:0] CountLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StWb} state_e;

  state_e           stateQ, stateD;
  logic [SHW-1:0]   countQ, countD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [2*WIDTH-1:0] mcandQ, mcandD;
  logic [WIDTH-1:0] mplierQ, mplierD;
  logic             mulWeQ, mulWeD;

  logic             outValidQ, outValidD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic [3:0]       nzvcQ, nzvcD;
  logic             resWeQ, resWeD;
  logic [3:0]       flagsQ, flagsD;

  logic             inReady;
  logic             inFire;
  logic             outFire;

  // Single-cycle datapath
  logic [SHW-1:0]   shAmt;
  logic [WIDTH:0]   addFull, subFull, shlFull, shrFull, asrFull;
  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluV;

  // Multiplier datapath
  logic [2*WIDTH-1:0] accStep;
  logic [WIDTH-1:0]   mulRes;
  logic               mulHi;

  assign inReady = (stateQ == StIdle) && (!outValidQ || bus.out_ready) && !reset;
  assign inFire  = bus.in_valid && inReady;
  assign outFire = outValidQ && bus.out_ready;

  assign shAmt   = bus.b[SHW-1:0];
  assign addFull = {1'b0, bus.a} + {1'b0, bus.b};
  assign subFull = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  // One extra bit on the shifted-out side catches the last bit shifted out as the carry.
  assign shlFull = {1'b0, bus.a} << shAmt;
  assign shrFull = {bus.a, 1'b0} >> shAmt;
  assign asrFull = $signed({bus.a, 1'b0}) >>> shAmt;

  always_comb begin
    aluRes = bus.a;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (bus.sel)
      OpAdd: begin
        aluRes = addFull[WIDTH-1:0];
        aluC   = addFull[WIDTH];
        aluV   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (aluRes[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        aluRes = subFull[WIDTH-1:0];
        aluC   = subFull[WIDTH];
        aluV   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (aluRes[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd: aluRes = bus.a & bus.b;
      OpOr:  aluRes = bus.a | bus.b;
      OpXor: aluRes = bus.a ^ bus.b;
      OpShl: begin
        aluRes = shlFull[WIDTH-1:0];
        aluC   = shlFull[WIDTH];
      end
      OpShr: begin
        aluRes = shrFull[WIDTH:1];
        aluC   = shrFull[0];
      end
      OpAsr: begin
        aluRes = asrFull[WIDTH:1];
        aluC   = asrFull[0];
      end
      default: begin
        aluRes = bus.a;
        aluC   = 1'b0;
        aluV   = 1'b0;
      end
    endcase
  end

  assign accStep = accQ + (mplierQ[0] ? mcandQ : '0);
  assign mulRes  = accQ[WIDTH-1:0];
  assign mulHi   = |accQ[2*WIDTH-1:WIDTH];

  always_comb begin
    stateD    = stateQ;
    countD    = countQ;
    accD      = accQ;
    mcandD    = mcandQ;
    mplierD   = mplierQ;
    mulWeD    = mulWeQ;
    outValidD = outValidQ && !outFire;
    resultD   = resultQ;
    nzvcD     = nzvcQ;
    resWeD    = resWeQ;
    flagsD    = (outFire && resWeQ) ? nzvcQ : flagsQ;

    unique case (stateQ)
      StIdle: begin
        if (inFire) begin
          if (bus.sel == OpMul) begin
            stateD  = StMul;
            countD  = '0;
            accD    = '0;
            mcandD  = {{WIDTH{1'b0}}, bus.a};
            mplierD = bus.b;
            mulWeD  = bus.flag_we;
          end else begin
            outValidD = 1'b1;
            resultD   = aluRes;
            nzvcD     = {aluRes[WIDTH-1], aluRes == '0, aluV, aluC};
            resWeD    = bus.flag_we;
          end
        end
      end
      StMul: begin
        accD    = accStep;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        countD  = countQ + 1'b1;
        if (countQ == CountLast) begin
          stateD = StWb;
        end
      end
      StWb: begin
        // Stall here until the output register is free or being emptied this cycle.
        if (!outValidQ || bus.out_ready) begin
          outValidD = 1'b1;
          resultD   = mulRes;
          nzvcD     = {mulRes[WIDTH-1], mulRes == '0, mulHi, mulHi};
          resWeD    = mulWeQ;
          stateD    = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      countQ    <= '0;
      accQ      <= '0;
      mcandQ    <= '0;
      mplierQ   <= '0;
      mulWeQ    <= 1'b0;
      outValidQ <= 1'b0;
      resultQ   <= '0;
      nzvcQ     <= '0;
      resWeQ    <= 1'b0;
      flagsQ    <= '0;
    end else begin
      stateQ    <= stateD;
      countQ    <= countD;
      accQ      <= accD;
      mcandQ    <= mcandD;
      mplierQ   <= mplierD;
      mulWeQ    <= mulWeD;
      outValidQ <= outValidD;
      resultQ   <= resultD;
      nzvcQ     <= nzvcD;
      resWeQ    <= resWeD;
      flagsQ    <= flagsD;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValidQ;
  assign bus.result    = resultQ;
  assign bus.n         = nzvcQ[3];
  assign bus.z         = nzvcQ[2];
  assign bus.v         = nzvcQ[1];
  assign bus.c         = nzvcQ[0];
  assign bus.flags_q   = flagsQ;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed scenarios plus randomized traffic with random
// back-pressure, checked against an arithmetic reference model.
module tb_alu_pipe;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  nzvc;
    logic        fwe;
  } expT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int       nTests;
  int       nFail;
  expT      sbq[$];
  logic [3:0] expFlags;
  bit       randMode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic expT model(input logic [15:0] ia, input logic [15:0] ib,
                                input logic [3:0] s, input logic fwe);
    expT e;
    int unsigned ua, ub, r;
    int sa, sb, rs, sh;
    longint unsigned p;
    bit cf, vf;
    ua = ia; ub = ib; sa = $signed(ia); sb = $signed(ib);
    sh = int'(ib[3:0]);
    cf = 0; vf = 0; r = ua;
    case (s)
      4'd0: begin r = ua + ub; cf = (ua + ub) > 32'hFFFF; vf = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin r = ua - ub; cf = ua >= ub; vf = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = ua << sh; cf = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
      4'd6: begin r = ua >> sh; cf = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'd7: begin rs = sa >>> sh; r = rs; cf = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'd8: begin p = longint'(ua) * longint'(ub); r = int'(p & 64'hFFFF); cf = (p >> 16) != 0; vf = cf; end
      default: r = ua;
    endcase
    e.res  = r[15:0];
    e.nzvc = {e.res[15], e.res == 16'h0, vf, cf};
    e.fwe  = fwe;
    return e;
  endfunction

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] isel,
                       input logic ifwe, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    #1;
    bus.in_valid = 1'b1; bus.a = ia; bus.b = ib; bus.sel = isel; bus.flag_we = ifwe;
    if (randMode) bus.out_ready = ($urandom_range(0, 3) != 0);
    while (!done && waits < 200) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      if (!done) begin
        waits++;
        #1;
        if (randMode) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (!done) begin
      nTests++; nFail++;
      $display("FAIL accept_timeout: in_ready never rose for sel %0d", isel);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      #1;
      bus.in_valid = 1'b0;
      if (randMode) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
    end
  endtask

  initial begin
    int w, lowCnt, readyHigh;
    bit seen;
    logic [15:0] held, ra, rb;
    logic [3:0]  heldNzvc, rsel;
    expT eb;

    nTests = 0; nFail = 0; expFlags = '0; randMode = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.flag_we = 1'b0;
    bus.out_ready = 1'b1;

    fork
      begin : monitor
        expT e;
        forever begin
          @(negedge clk);
          chk("flags_q", bus.flags_q, expFlags);
          if (reset) begin
            chk("in_ready_during_reset", bus.in_ready, 1'b0);
            sbq.delete();
            expFlags = '0;
          end else begin
            if (bus.out_valid && bus.out_ready) begin
              if (sbq.size() == 0) begin
                nTests++; nFail++;
                $display("FAIL unexpected_output: got %0h expected none", bus.result);
              end else begin
                e = sbq.pop_front();
                chk("result", bus.result, e.res);
                chk("nzvc", {bus.n, bus.z, bus.v, bus.c}, e.nzvc);
                if (e.fwe) expFlags = e.nzvc;
              end
            end
            if (bus.in_valid && bus.in_ready)
              sbq.push_back(model(bus.a, bus.b, bus.sel, bus.flag_we));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 16'h0);
    chk("rst_nzvc", {bus.n, bus.z, bus.v, bus.c}, 4'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);

    // ADD overflow, latency 1, sticky flags
    drive(16'h7FFF, 16'h0001, 4'd0, 1'b1, w);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_latency_valid", bus.out_valid, 1'b1);
    chk("add_result", bus.result, 16'h8000);
    @(posedge clk);
    @(negedge clk);
    chk("add_sticky", bus.flags_q, 4'b1010);
    @(posedge clk);

    // Back-to-back SUBs
    drive(16'h0005, 16'h0005, 4'd1, 1'b0, w);
    drive(16'h0000, 16'h0001, 4'd1, 1'b0, w);
    chk("sub_b2b_no_wait", w, 0);
    idle(2);

    // Shifts
    drive(16'h8001, 16'h0001, 4'd5, 1'b1, w);
    drive(16'h8000, 16'h000F, 4'd7, 1'b1, w);
    drive(16'h0001, 16'h0000, 4'd6, 1'b1, w);
    idle(2);

    // MUL latency: output register loads 17 edges after the accepting edge
    drive(16'h0100, 16'h0100, 4'd8, 1'b1, w);
    #1 bus.in_valid = 1'b0;
    lowCnt = 0; readyHigh = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
      else begin
        lowCnt++;
        if (bus.in_ready) readyHigh++;
      end
    end
    chk("mul_latency", lowCnt, 17);
    chk("mul_in_ready_low", readyHigh, 0);
    @(posedge clk);
    idle(1);

    // Back-pressure: second op must wait, first result held stable
    #1 bus.out_ready = 1'b0;
    drive(16'h8000, 16'h8000, 4'd0, 1'b1, w);
    #1 bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sel = 4'd4; bus.flag_we = 1'b1;
    @(negedge clk);
    held = bus.result; heldNzvc = {bus.n, bus.z, bus.v, bus.c};
    chk("bp_first_result", held, 16'h0000);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_valid_held", bus.out_valid, 1'b1);
      chk("bp_result_held", bus.result, held);
      chk("bp_flags_held", {bus.n, bus.z, bus.v, bus.c}, heldNzvc);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drive(16'hFFFF, 16'h0001, 4'd4, 1'b1, w);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    eb = model(16'hFFFF, 16'h0001, 4'd4, 1'b1);
    chk("bp_replace_valid", bus.out_valid, 1'b1);
    chk("bp_replace_result", bus.result, eb.res);
    @(posedge clk);
    idle(2);

    // Reset in the middle of a multiply
    drive(16'h0003, 16'h0005, 4'd8, 1'b1, w);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mulrst_out_valid", bus.out_valid, 1'b0);
    chk("mulrst_flags_q", bus.flags_q, 4'h0);
    @(posedge clk);
    drive(16'h0003, 16'h0005, 4'd8, 1'b1, w);
    idle(20);

    // Randomized traffic with random back-pressure
    randMode = 1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 1));
      ra   = $urandom_range(0, 65535);
      rb   = $urandom_range(0, 65535);
      rsel = $urandom_range(0, 15);
      case ($urandom_range(0, 7))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        3: rb = 16'h0000;
        default: ;
      endcase
      drive(ra, rb, rsel, $urandom_range(0, 1), w);
    end
    randMode = 0;
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && (sbq.size() != 0 || bus.out_valid); i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sbq.size(), 0);
    chk("drain_out_valid", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU in the processor's execute stage.
- Adds valid/ready handshaking on input and output, a registered result stage, and a barrel shifter that takes its shift amount from B.
- Adds an iterative shift-add multiplier and a sticky status-flag register that the execute stage reads for conditional instructions.

Parameters:
- WIDTH, 16, datapath width in bits; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit accepts the operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount
- sel  in  4  opcode
- flag_we  in  1  update sticky flags when this op's result is consumed
- out_valid  out  1  result register holds valid data
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- n, z, v, c  out  1 each  flags of the current result
- flags_q  out  4  sticky {N,Z,V,C}

Behaviour:
- Reset: in_ready=0 during the reset cycle. After reset: out_valid=0, result=0, n=z=v=c=0, flags_q=0, FSM=IDLE, mul counter=0. Reset mid-multiply aborts the operation with no output.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops sustain 1 op/clk.
- Opcodes, with flags:
  - 0 ADD: C = carry out; V = signed overflow.
  - 1 SUB: computed as A + ~B + 1; C = carry out (1 = no borrow); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 SHL by b[SHW-1:0]: C = last bit shifted out; amount 0 gives result A and C=0.
  - 6 SHR (logical), 7 ASR (sign fill): C as SHL; V=0 for all shifts.
  - 8 MUL (unsigned, low WIDTH bits of the product): C = V = (high half of the 2*WIDTH product != 0).
  - 9..15: pass A; C=0, V=0.
  - All opcodes: N = result[WIDTH-1]; Z = (result==0).
- Single-cycle ops (0–7, 9–15): if accepted at edge k, result and flags are registered at edge k, so out_valid=1 in cycle k+1. Latency 1.
- MUL FSM:
  - IDLE → MUL on input transfer with sel=8. Latch a and b; clear the 2*WIDTH accumulator; count=0.
  - MUL: one shift-add step per cycle; count increments.
  - After WIDTH steps → WB.
  - WB: load result/flags when !out_valid || out_ready, then → IDLE; otherwise stay in WB (stall).
  - Minimum latency WIDTH+1 cycles from acceptance to out_valid. in_ready=0 throughout MUL/WB.
- Output register:
  - Holds result and flags stable while out_valid && !out_ready.
  - Cleared (out_valid←0) on output transfer unless a new result loads the same edge, in which case the new result replaces it and out_valid stays 1.
- Sticky flags: each result carries its captured flag_we. flags_q ← {n,z,v,c} on the output transfer of a result whose flag_we was 1; otherwise flags_q is unchanged.
- No combinational path from a/b/sel to result; in_ready depends only on state, out_valid and out_ready.

Test Plan (WIDTH=16):
- Reset, then ADD a=7FFF, b=0001 with flag_we=1, out_ready=1 → result=8000, N=1 Z=0 V=1 C=0 one cycle after acceptance; flags_q=1010 after the output transfer.
- SUB a=0005, b=0005 followed next cycle by SUB a=0000, b=0001 → first result 0000 with Z=1 C=1; second result FFFF with N=1 C=0 V=0; in_ready stays 1 (1 op/clk).
- SHL a=8001, b=0001 → result 0002, C=1. ASR a=8000, b=000F → FFFF, C=0. SHR a=0001, b=0000 → 0001, C=0.
- MUL a=0100, b=0100 with out_ready=1 → result 0000, Z=1, C=V=1; out_valid rises exactly 17 cycles after acceptance; in_ready=0 for 17 cycles.
- Hold out_ready=0 with a result pending, drive in_valid with a second op → in_ready=0, result/flags stable; raise out_ready → both results delivered in order with no loss.
- Assert reset at step 8 of MUL a=0003, b=0005 → after reset out_valid=0, flags_q=0; a following MUL a=0003, b=0005 returns 000F with C=V=0.
